// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU with a start/ready/done handshake.
// Single-cycle logic/arith/branch ops plus iterative unsigned multiply and divide.
module multicycle_alu #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] ip_0,
    input  logic [WIDTH-1:0] ip_1,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] op_0,
    output logic [WIDTH-1:0] op_1,
    output logic             change_pc,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BLT  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BGE  = 4'b1011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic             is_div;

    logic [WIDTH-1:0] sc_op0;
    logic             sc_pc;
    logic             sc_err;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED_CMP)
            return $signed(a) < $signed(b);
        else
            return a < b;
    endfunction

    always_comb begin
        sc_op0 = '0;
        sc_pc  = 1'b0;
        sc_err = 1'b0;
        case (opcode)
            OP_BEQ:           sc_pc  = (ip_0 == ip_1);
            OP_BNE:           sc_pc  = (ip_0 != ip_1);
            OP_BLT:           sc_pc  = less_than(ip_0, ip_1);
            OP_BGE:           sc_pc  = !less_than(ip_0, ip_1);
            OP_ADD:           sc_op0 = ip_0 + ip_1;
            OP_SUB:           sc_op0 = ip_0 - ip_1;
            OP_AND:           sc_op0 = ip_0 & ip_1;
            OP_OR:            sc_op0 = ip_0 | ip_1;
            OP_MUL, OP_DIVU:  sc_op0 = '0;
            default:          sc_err = 1'b1;
        endcase
    end

    // Multiply keeps the multiplier in op_0 and the partial product in op_1;
    // divide keeps the dividend/quotient in op_0 and the remainder in op_1.
    always_comb begin
        mul_sum    = {1'b0, op_1} + (op_0[0] ? {1'b0, divisor} : '0);
        div_rem_sh = {op_1, op_0[WIDTH-1]};
        div_diff   = div_rem_sh - {1'b0, divisor};
        div_ge     = !div_diff[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            op_0      <= '0;
            op_1      <= '0;
            change_pc <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            divisor   <= '0;
            is_div    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ready     <= 1'b0;
                        change_pc <= 1'b0;
                        err       <= 1'b0;
                        if ((opcode == OP_MUL || opcode == OP_DIVU) && ip_1 != '0) begin
                            state   <= RUN;
                            cnt     <= CNT_W'(WIDTH);
                            divisor <= ip_1;
                            is_div  <= (opcode == OP_DIVU);
                            op_0    <= ip_0;
                            op_1    <= '0;
                        end else if (opcode == OP_DIVU) begin
                            state <= DONE;
                            done  <= 1'b1;
                            op_0  <= '1;
                            op_1  <= ip_0;
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            op_0      <= sc_op0;
                            op_1      <= '0;
                            change_pc <= sc_pc;
                            err       <= sc_err;
                        end
                    end
                end
                RUN: begin
                    if (is_div) begin
                        op_1 <= div_ge ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0];
                        op_0 <= {op_0[WIDTH-2:0], div_ge};
                    end else begin
                        op_1 <= mul_sum[WIDTH:1];
                        op_0 <= {mul_sum[0], op_0[WIDTH-1:1]};
                    end
                    cnt <= cnt - CNT_W'(1);
                    // The WIDTH-th iteration lands in the same edge that raises done.
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: one unsigned-compare and one signed-compare
// instance share the same stimulus.
module tb_multicycle_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   opcode = 4'b0;
    logic [W-1:0] ip_0 = '0;
    logic [W-1:0] ip_1 = '0;

    logic         ready_u, done_u, pc_u, err_u;
    logic [W-1:0] op0_u, op1_u;
    logic         ready_s, done_s, pc_s, err_s;
    logic [W-1:0] op0_s, op1_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic         epc_u;
        logic         epc_s;
        logic         eerr;
    } vec_t;

    vec_t vecs[18];

    multicycle_alu #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_alu_u (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ip_0(ip_0), .ip_1(ip_1),
        .ready(ready_u), .done(done_u), .op_0(op0_u), .op_1(op1_u),
        .change_pc(pc_u), .err(err_u)
    );

    multicycle_alu #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_alu_s (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ip_0(ip_0), .ip_1(ip_1),
        .ready(ready_s), .done(done_s), .op_0(op0_s), .op_1(op1_s),
        .change_pc(pc_s), .err(err_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int lat, input logic [W-1:0] e0, input logic [W-1:0] e1,
                                input logic epc_u, input logic epc_s, input logic eerr);
        vec_t v;
        v.opc = opc; v.a = a; v.b = b; v.lat = lat; v.e0 = e0; v.e1 = e1;
        v.epc_u = epc_u; v.epc_s = epc_s; v.eerr = eerr;
        return v;
    endfunction

    task automatic check_reset_state(input int idx);
        chk("rst_ready_u", idx, 64'(ready_u), 64'd1);
        chk("rst_ready_s", idx, 64'(ready_s), 64'd1);
        chk("rst_done", idx, 64'({done_u, done_s}), 64'd0);
        chk("rst_op0", idx, 64'(op0_u), 64'd0);
        chk("rst_op1", idx, 64'(op1_u), 64'd0);
        chk("rst_pc_err", idx, 64'({pc_u, err_u, pc_s, err_s}), 64'd0);
        chk("rst_op_s", idx, {op0_s, op1_s}, 64'd0);
    endtask

    // Issue one operation, optionally poking start while it runs, and check
    // latency, the done-cycle outputs and the held values one cycle later.
    task automatic run_op(input vec_t v, input int idx, input bit poke);
        int cyc;
        @(negedge clk);
        chk("ready_before", idx, 64'(ready_u), 64'd1);
        start = 1'b1; opcode = v.opc; ip_0 = v.a; ip_1 = v.b;
        @(negedge clk);
        start = 1'b0; opcode = 4'($urandom); ip_0 = $urandom; ip_1 = $urandom;
        cyc = 1;
        while (!done_u && cyc < W + 10) begin
            if (poke) begin
                start = (cyc >= 5 && cyc < 8);
                opcode = 4'b0100;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", idx, 64'(cyc), 64'(v.lat));
        chk("done_u", idx, 64'(done_u), 64'd1);
        chk("done_s", idx, 64'(done_s), 64'd1);
        chk("ready_in_done", idx, 64'(ready_u), 64'd0);
        chk("op_0", idx, 64'(op0_u), 64'(v.e0));
        chk("op_1", idx, 64'(op1_u), 64'(v.e1));
        chk("op_0_s", idx, 64'(op0_s), 64'(v.e0));
        chk("change_pc_u", idx, 64'(pc_u), 64'(v.epc_u));
        chk("change_pc_s", idx, 64'(pc_s), 64'(v.epc_s));
        chk("err", idx, 64'(err_u), 64'(v.eerr));
        @(negedge clk);
        chk("done_pulse_end", idx, 64'(done_u), 64'd0);
        chk("ready_after", idx, 64'(ready_u), 64'd1);
        chk("hold", idx, {op0_u, op1_u}, {v.e0, v.e1});
        chk("hold_flags", idx, 64'({pc_u, err_u}), 64'({v.epc_u, v.eerr}));
    endtask

    initial begin
        int done_seen;

        vecs[0]  = mk(4'b0100, 32'h0000_0005, 32'hFFFF_FFFF, 1,      32'h0000_0004, 32'h0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(4'b0101, 32'd3,         32'd5,         1,      32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1,      32'hF000_F000, 32'h0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1,      32'hFFF0_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'b0010, 32'd7,         32'd7,         1,      32'h0,         32'h0, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(4'b1010, 32'd7,         32'd7,         1,      32'h0,         32'h0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(4'b0011, 32'hFFFF_FFFF, 32'd1,         1,      32'h0,         32'h0, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(4'b1011, 32'd1,         32'hFFFF_FFFF, 1,      32'h0,         32'h0, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(4'b0011, 32'd5,         32'd5,         1,      32'h0,         32'h0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(4'b1011, 32'd5,         32'd5,         1,      32'h0,         32'h0, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(4'b0010, 32'd7,         32'd8,         1,      32'h0,         32'h0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, W + 1,  32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(4'b1000, 32'h0001_0000, 32'h0001_0000, W + 1,  32'h0,         32'h1, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(4'b1001, 32'd100,       32'd7,         W + 1,  32'd14,        32'd2, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(4'b1001, 32'hFFFF_FFFF, 32'd10,        W + 1,  32'h1999_9999, 32'd5, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(4'b1001, 32'd9,         32'd0,         1,      32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(4'b1111, 32'd12,        32'd34,        1,      32'h0,         32'h0, 1'b0, 1'b0, 1'b1);
        vecs[17] = mk(4'b1000, 32'd1234,      32'd0,         1,      32'h0,         32'h0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_reset_state(100);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) run_op(vecs[i], i, 1'b0);

        // Start pulses during a multiply must be ignored.
        run_op(vecs[11], 200, 1'b1);

        // Reset ten cycles into a multiply aborts it with no done pulse.
        @(negedge clk);
        start = 1'b1; opcode = 4'b1000; ip_0 = 32'hFFFF_FFFF; ip_1 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state(300);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            if (done_u || done_s) done_seen++;
        end
        chk("no_done_after_abort", 300, 64'(done_seen), 64'd0);
        run_op(mk(4'b0000, 32'd5, 32'd6, 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1), 301, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
